pc_ras_unit: RTL and testbench

//  Parametrised program-counter unit for the multi-cycle core. Advances the PC once
//  per execute pulse: sequential step, JMP, and flag-conditional BEQ/BL/BG.

---
 rtl/pc_ras_unit_if.sv | 29 ++
 rtl/pc_ras_unit.sv | 135 +++++++++++++
 tb/tb_pc_ras_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ras_unit_if.sv
// Purpose: execute-stage to PC-unit bundle: execute strobe, opcode, flags, target in; fetch address and RAS status out.
// Latency: none (wiring only).
// Backpressure: none; en_exe_pulse is a one-cycle strobe that is never stalled.
interface pc_ras_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              en_exe_pulse;
  logic [4:0]        opcode;
  logic [1:0]        flag;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] ins_address;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf;
  logic              ras_unf;
  logic              misalign;

  // Decode/execute side: drives the strobe and operands, observes the PC.
  modport master (
    output en_exe_pulse, opcode, flag, imm_ext,
    input  ins_address, ras_empty, ras_full, ras_ovf, ras_unf, misalign
  );

  // PC unit side.
  modport slave (
    input  en_exe_pulse, opcode, flag, imm_ext,
    output ins_address, ras_empty, ras_full, ras_ovf, ras_unf, misalign
  );
endinterface

// File: rtl/pc_ras_unit.sv
// Purpose: program counter with JMP/BEQ/BL/BG and CALL/RET through a circular return-address stack.
// Latency: 1 cycle from the en_exe_pulse edge to the new ins_address and status/pulse outputs.
// Backpressure: none; state holds whenever en_exe_pulse is low. Optional PC_ALIGN_CHECK_EN rejects unaligned targets.
module pc_ras_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] STEP       = ADDR_W'(4)
) (
  input logic          clk,
  input logic          reset,
  pc_ras_unit_if.slave bus
);
  localparam int unsigned SP_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = SP_W + 1;

  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_BEQ  = 5'b11001;
  localparam logic [4:0] OP_BL   = 5'b11010;
  localparam logic [4:0] OP_BG   = 5'b11011;
  localparam logic [4:0] OP_CALL = 5'b11100;
  localparam logic [4:0] OP_RET  = 5'b11101;

  // sp points at the next free slot; the top of stack lives at sp-1.
  // When full, sp also points at the oldest entry, so a push overwrites it.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [ADDR_W-1:0] pc_q;
  logic [SP_W-1:0]   sp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              empty_q, full_q, ovf_q, unf_q, mis_q;

  logic [ADDR_W-1:0] pc_inc, target, pc_nxt;
  logic [SP_W-1:0]   top_idx, sp_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              taken, push, pop, ovf, unf, mis;

  // Decode the opcode into a next PC and the stack operation it implies.
  always_comb begin
    pc_inc  = pc_q + STEP;
    top_idx = sp_q - SP_W'(1);
    target  = bus.imm_ext;
    pc_nxt  = pc_inc;
    taken   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unf     = 1'b0;
    mis     = 1'b0;
    case (bus.opcode)
      OP_JMP:  taken = 1'b1;
      OP_BEQ:  taken = (bus.flag == 2'b01);
      OP_BL:   taken = (bus.flag == 2'b10);
      OP_BG:   taken = (bus.flag == 2'b11);
      OP_CALL: begin
        taken = 1'b1;
        push  = 1'b1;
      end
      OP_RET: begin
        if (empty_q) begin
          unf = 1'b1;
        end else begin
          taken  = 1'b1;
          pop    = 1'b1;
          target = ras_mem[top_idx];
        end
      end
      default: ;
    endcase
    if (taken) begin
`ifdef PC_ALIGN_CHECK_EN
      // A rejected CALL must not push; a rejected RET has already popped.
      if (target[1:0] != 2'b00) begin
        mis  = 1'b1;
        push = 1'b0;
      end else begin
        pc_nxt = target;
      end
`else
      pc_nxt = target;
`endif
    end
    ovf = push && full_q;
  end

  // Stack pointer and occupancy follow the push/pop decision.
  always_comb begin
    sp_nxt  = sp_q;
    cnt_nxt = cnt_q;
    if (push) begin
      sp_nxt = sp_q + SP_W'(1);
      if (!full_q) cnt_nxt = cnt_q + CNT_W'(1);
    end else if (pop) begin
      sp_nxt  = top_idx;
      cnt_nxt = cnt_q - CNT_W'(1);
    end
  end

  // Architectural state: PC, stack pointer, count, status flags and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      sp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      ovf_q <= bus.en_exe_pulse && ovf;
      unf_q <= bus.en_exe_pulse && unf;
      mis_q <= bus.en_exe_pulse && mis;
      if (bus.en_exe_pulse) begin
        pc_q    <= pc_nxt;
        sp_q    <= sp_nxt;
        cnt_q   <= cnt_nxt;
        empty_q <= (cnt_nxt == '0);
        full_q  <= (cnt_nxt == CNT_W'(RAS_DEPTH));
      end
    end
  end

  // Return-address storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (!reset && bus.en_exe_pulse && push) begin
      ras_mem[sp_q] <= pc_inc;
    end
  end

  assign bus.ins_address = pc_q;
  assign bus.ras_empty   = empty_q;
  assign bus.ras_full    = full_q;
  assign bus.ras_ovf     = ovf_q;
  assign bus.ras_unf     = unf_q;
  assign bus.misalign    = mis_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Purpose: self-checking bench for pc_ras_unit: directed vector table, RAS corner sequences, random vs queue model.
// Latency: outputs sampled 1 ns after the edge that consumes each stimulus.
// Backpressure: none; one stimulus per clock.
module tb_pc_ras_unit;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 8;

  localparam logic [4:0] JMP  = 5'b11000;
  localparam logic [4:0] BEQ  = 5'b11001;
  localparam logic [4:0] BL   = 5'b11010;
  localparam logic [4:0] BG   = 5'b11011;
  localparam logic [4:0] CALL = 5'b11100;
  localparam logic [4:0] RET  = 5'b11101;
  localparam logic [4:0] NOP  = 5'b00000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_ras_unit_if #(.ADDR_W(AW)) bus ();

  pc_ras_unit #(
    .ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_ADDR(32'h0), .STEP(32'd4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: PC plus a bounded queue of return addresses (newest at back).
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_ovf, m_unf, m_mis;

  typedef struct {
    bit          en;
    logic [4:0]  op;
    logic [1:0]  fl;
    logic [31:0] imm;
    logic [31:0] pc;
    bit          empty;
    bit          full;
    bit          ovf;
    bit          unf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input logic [4:0] op,
                            input logic [1:0] fl, input logic [31:0] imm);
    logic [31:0] tgt;
    logic [31:0] ret_addr;
    bit          take;
    bit          is_call;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_mis = 1'b0;
    if (rst) begin
      m_pc = 32'h0;
      m_q.delete();
      return;
    end
    if (!en) return;
    ret_addr = m_pc + 32'd4;
    tgt      = imm;
    take     = 1'b0;
    is_call  = 1'b0;
    case (op)
      JMP:  take = 1'b1;
      BEQ:  take = (fl == 2'b01);
      BL:   take = (fl == 2'b10);
      BG:   take = (fl == 2'b11);
      CALL: begin take = 1'b1; is_call = 1'b1; end
      RET: begin
        if (m_q.size() == 0) m_unf = 1'b1;
        else begin tgt = m_q.pop_back(); take = 1'b1; end
      end
      default: ;
    endcase
    if (!take) begin
      m_pc = ret_addr;
      return;
    end
`ifdef PC_ALIGN_CHECK_EN
    if (tgt[1:0] != 2'b00) begin
      m_mis = 1'b1;
      m_pc  = ret_addr;
      return;
    end
`endif
    m_pc = tgt;
    if (is_call) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1'b1;
      end
      m_q.push_back(ret_addr);
    end
  endtask

  task automatic apply(input bit rst, input bit en, input logic [4:0] op,
                       input logic [1:0] fl, input logic [31:0] imm);
    @(negedge clk);
    reset            = rst;
    bus.en_exe_pulse = en;
    bus.opcode       = op;
    bus.flag         = fl;
    bus.imm_ext      = imm;
    @(posedge clk);
    #1;
    model_step(rst, en, op, fl, imm);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    bus.ins_address, m_pc);
    chk({tag, ".empty"}, 32'(bus.ras_empty), 32'(m_q.size() == 0));
    chk({tag, ".full"},  32'(bus.ras_full),  32'(m_q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(bus.ras_ovf),   32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.ras_unf),   32'(m_unf));
    chk({tag, ".mis"},   32'(bus.misalign),  32'(m_mis));
  endtask

  initial begin
    vec_t        tbl[18];
    logic [4:0]  ops[10];
    logic [4:0]  op;
    logic [31:0] imm;

    tbl[0]  = '{1, NOP,  2'b00, 32'h0,     32'h4,   1, 0, 0, 0};
    tbl[1]  = '{1, NOP,  2'b00, 32'h0,     32'h8,   1, 0, 0, 0};
    tbl[2]  = '{1, NOP,  2'b00, 32'h0,     32'hC,   1, 0, 0, 0};
    tbl[3]  = '{0, NOP,  2'b00, 32'h0,     32'hC,   1, 0, 0, 0};
    tbl[4]  = '{0, JMP,  2'b00, 32'h500,   32'hC,   1, 0, 0, 0};
    tbl[5]  = '{1, BEQ,  2'b10, 32'h100,   32'h10,  1, 0, 0, 0};
    tbl[6]  = '{1, BEQ,  2'b01, 32'h100,   32'h100, 1, 0, 0, 0};
    tbl[7]  = '{1, BG,   2'b11, 32'h180,   32'h180, 1, 0, 0, 0};
    tbl[8]  = '{1, BL,   2'b01, 32'h300,   32'h184, 1, 0, 0, 0};
    tbl[9]  = '{1, JMP,  2'b00, 32'h10,    32'h10,  1, 0, 0, 0};
    tbl[10] = '{1, CALL, 2'b00, 32'h200,   32'h200, 0, 0, 0, 0};
    tbl[11] = '{1, RET,  2'b00, 32'h0,     32'h14,  1, 0, 0, 0};
    tbl[12] = '{1, CALL, 2'b00, 32'h400,   32'h400, 0, 0, 0, 0};
    tbl[13] = '{1, CALL, 2'b00, 32'h800,   32'h800, 0, 0, 0, 0};
    tbl[14] = '{1, RET,  2'b00, 32'h0,     32'h404, 0, 0, 0, 0};
    tbl[15] = '{1, RET,  2'b00, 32'h0,     32'h18,  1, 0, 0, 0};
    tbl[16] = '{1, RET,  2'b00, 32'h0,     32'h1C,  1, 0, 0, 1};
    tbl[17] = '{0, RET,  2'b00, 32'h0,     32'h1C,  1, 0, 0, 0};

    ops = '{NOP, JMP, BEQ, BL, BG, CALL, RET, CALL, RET, 5'b11111};

    // Reset held for two cycles.
    bus.en_exe_pulse = 1'b0;
    bus.opcode       = NOP;
    bus.flag         = 2'b00;
    bus.imm_ext      = 32'h0;
    reset            = 1'b1;
    apply(1, 0, NOP, 2'b00, 32'h0);
    apply(1, 0, NOP, 2'b00, 32'h0);
    chk("reset.pc",    bus.ins_address, 32'h0);
    chk("reset.empty", 32'(bus.ras_empty), 32'd1);
    chk("reset.full",  32'(bus.ras_full),  32'd0);
    chk("reset.ovf",   32'(bus.ras_ovf),   32'd0);
    chk("reset.unf",   32'(bus.ras_unf),   32'd0);

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      apply(0, tbl[i].en, tbl[i].op, tbl[i].fl, tbl[i].imm);
      chk($sformatf("vec%0d.pc", i),    bus.ins_address, tbl[i].pc);
      chk($sformatf("vec%0d.empty", i), 32'(bus.ras_empty), 32'(tbl[i].empty));
      chk($sformatf("vec%0d.full", i),  32'(bus.ras_full),  32'(tbl[i].full));
      chk($sformatf("vec%0d.ovf", i),   32'(bus.ras_ovf),   32'(tbl[i].ovf));
      chk($sformatf("vec%0d.unf", i),   32'(bus.ras_unf),   32'(tbl[i].unf));
      chk($sformatf("vec%0d.mis", i),   32'(bus.misalign),  32'd0);
    end

    // Nine CALLs on an eight-deep stack: the ninth overwrites the oldest (0x20).
    for (int k = 1; k <= 9; k++) begin
      apply(0, 1, CALL, 2'b00, 32'h1000 * k);
      check_model($sformatf("call%0d", k));
    end
    chk("call9.ovf_pulse", 32'(bus.ras_ovf), 32'd1);
    chk("call9.full",      32'(bus.ras_full), 32'd1);
    apply(0, 0, NOP, 2'b00, 32'h0);
    chk("idle.ovf_clear", 32'(bus.ras_ovf), 32'd0);

    // Eight RETs unwind newest-first, the ninth underflows.
    for (int i = 1; i <= 8; i++) begin
      apply(0, 1, RET, 2'b00, 32'h0);
      chk($sformatf("ret%0d.pc", i), bus.ins_address, 32'h1000 * (9 - i) + 32'h4);
      check_model($sformatf("ret%0d", i));
    end
    apply(0, 1, RET, 2'b00, 32'h0);
    chk("ret9.unf_pulse", 32'(bus.ras_unf), 32'd1);
    chk("ret9.pc",        bus.ins_address, 32'h1008);
    check_model("ret9");

    // PC wraps at the top of the address space.
    apply(0, 1, JMP, 2'b00, 32'hFFFF_FFFC);
    apply(0, 1, NOP, 2'b00, 32'h0);
    chk("wrap.pc", bus.ins_address, 32'h0);

    // Reset beats a concurrent CALL and discards it.
    apply(0, 1, CALL, 2'b00, 32'h40);
    apply(1, 1, CALL, 2'b00, 32'h80);
    chk("rstcall.pc",    bus.ins_address, 32'h0);
    chk("rstcall.empty", 32'(bus.ras_empty), 32'd1);
    apply(0, 1, RET, 2'b00, 32'h0);
    chk("rstcall.unf", 32'(bus.ras_unf), 32'd1);
    chk("rstcall.ret_pc", bus.ins_address, 32'h4);

`ifdef PC_ALIGN_CHECK_EN
    apply(0, 1, JMP, 2'b00, 32'h102);
    chk("align.mis", 32'(bus.misalign), 32'd1);
    chk("align.pc",  bus.ins_address, 32'h8);
    apply(0, 1, CALL, 2'b00, 32'h201);
    chk("align.call_nopush", 32'(bus.ras_empty), 32'd1);
    check_model("align.call");
`endif

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      op  = ops[$urandom_range(0, 9)];
      imm = $urandom;
      if ($urandom_range(0, 7) != 0) imm[1:0] = 2'b00;
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, op,
            2'($urandom_range(0, 3)), imm);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
